controlador_ataque: RTL and testbench

CONTROLADOR_ATAQUE -- requirements
Module: controlador_ataque

---
 rtl/controlador_ataque.sv | 216 +++++++++++++++++++++
 tb/tb_controlador_ataque.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_ataque.sv
// controlador_ataque: shot evaluation and score keeping for the ATAQUE phase
// of a 7x5 naval battle board.
// Build option: define TIRO_REPETIDO_PENALIDADE_EN to charge a life for a
// repeated valid cell. When it is undefined, a repeated cell is answered as invalid.
//
// state   | meaning
// OCIOSO  | idle; boards and counters cleared, lives reloaded
// ARMA    | one cycle; count ships in the confirmed map
// ESPERA  | waiting for a fire edge (pendente_q marks a latched shot)
// AVALIA  | one cycle; evaluate the latched coordinate
// VITORIA | all ships hit, board frozen
// DERROTA | out of lives, board frozen
module controlador_ataque #(
  parameter int unsigned VIDAS_INICIAIS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] linha,
  input  logic [2:0] coluna,
  input  logic       disparo,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic [6:0] tiro0,
  output logic [6:0] tiro1,
  output logic [6:0] tiro2,
  output logic [6:0] tiro3,
  output logic [6:0] tiro4,
  output logic [6:0] acerto0,
  output logic [6:0] acerto1,
  output logic [6:0] acerto2,
  output logic [6:0] acerto3,
  output logic [6:0] acerto4,
  output logic [3:0] vidas,
  output logic [5:0] acertos,
  output logic       resp_acerto,
  output logic       resp_erro,
  output logic       resp_invalido,
  output logic       vitoria,
  output logic       derrota
);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] ARMA    = 3'd1;
  localparam logic [2:0] ESPERA  = 3'd2;
  localparam logic [2:0] AVALIA  = 3'd3;
  localparam logic [2:0] VITORIA = 3'd4;
  localparam logic [2:0] DERROTA = 3'd5;

  localparam logic [3:0] VIDAS_INI = 4'(VIDAS_INICIAIS);

  logic [2:0]      estado_q, estado_d;
  logic [4:0][6:0] tiro_q, tiro_d;
  logic [4:0][6:0] acerto_q, acerto_d;
  logic [3:0]      vidas_q, vidas_d;
  logic [5:0]      acertos_q, acertos_d;
  logic [5:0]      total_q, total_d;
  logic [2:0]      linha_q, linha_d;
  logic [2:0]      coluna_q, coluna_d;
  logic            pendente_q, pendente_d;
  logic            disparo_q, disparo_d;
  logic            resp_acerto_q, resp_acerto_d;
  logic            resp_erro_q, resp_erro_d;
  logic            resp_invalido_q, resp_invalido_d;

  logic [4:0][6:0] mapa;
  logic [34:0]     mapa_plano;
  logic [5:0]      contagem;
  logic            borda;
  logic            coord_invalida;
  logic            ja_atirado;
  logic            navio;
  logic            erro;

  assign mapa       = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign mapa_plano = mapa;

  assign borda          = disparo & ~disparo_q;
  assign coord_invalida = (linha_q > 3'd6) || (coluna_q > 3'd4);
  assign ja_atirado     = tiro_q[coluna_q][linha_q];
  assign navio          = mapa[coluna_q][linha_q];

  // Ship count of the live map, latched only in ARMA.
  always_comb begin
    contagem = '0;
    for (int i = 0; i < 35; i++) begin
      contagem = contagem + {5'd0, mapa_plano[i]};
    end
  end

  // Next-state, board and counter updates.
  always_comb begin
    estado_d        = estado_q;
    tiro_d          = tiro_q;
    acerto_d        = acerto_q;
    vidas_d         = vidas_q;
    acertos_d       = acertos_q;
    total_d         = total_q;
    linha_d         = linha_q;
    coluna_d        = coluna_q;
    pendente_d      = pendente_q;
    disparo_d       = disparo;
    resp_acerto_d   = 1'b0;
    resp_erro_d     = 1'b0;
    resp_invalido_d = 1'b0;
    erro            = 1'b0;

    if (!enable || estado_q == OCIOSO) begin
      // Leaving the game discards any latched shot and wipes the board.
      tiro_d     = '0;
      acerto_d   = '0;
      vidas_d    = VIDAS_INI;
      acertos_d  = '0;
      pendente_d = 1'b0;
      estado_d   = enable ? ARMA : OCIOSO;
    end else begin
      case (estado_q)
        ARMA: begin
          total_d  = contagem;
          estado_d = (contagem == 6'd0) ? VITORIA : ESPERA;
        end
        ESPERA: begin
          if (pendente_q) begin
            pendente_d = 1'b0;
            estado_d   = AVALIA;
          end else if (borda) begin
            linha_d    = linha;
            coluna_d   = coluna;
            pendente_d = 1'b1;
          end
        end
        AVALIA: begin
          estado_d = ESPERA;
          if (coord_invalida) begin
            resp_invalido_d = 1'b1;
          end else if (ja_atirado) begin
`ifdef TIRO_REPETIDO_PENALIDADE_EN
            erro = 1'b1;
`else
            resp_invalido_d = 1'b1;
`endif
          end else if (navio) begin
            tiro_d[coluna_q][linha_q]   = 1'b1;
            acerto_d[coluna_q][linha_q] = 1'b1;
            acertos_d                   = acertos_q + 6'd1;
            resp_acerto_d               = 1'b1;
            if (acertos_q + 6'd1 == total_q) begin
              estado_d = VITORIA;
            end
          end else begin
            erro = 1'b1;
          end
          if (erro) begin
            tiro_d[coluna_q][linha_q] = 1'b1;
            resp_erro_d               = 1'b1;
            if (vidas_q != 4'd0) begin
              vidas_d = vidas_q - 4'd1;
            end
            if (vidas_q <= 4'd1) begin
              estado_d = DERROTA;
            end
          end
        end
        VITORIA, DERROTA: estado_d = estado_q;
        default:          estado_d = OCIOSO;
      endcase
    end
  end

  // State registers; the fire copy resets high so a held button cannot fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q        <= OCIOSO;
      tiro_q          <= '0;
      acerto_q        <= '0;
      vidas_q         <= VIDAS_INI;
      acertos_q       <= '0;
      total_q         <= '0;
      linha_q         <= '0;
      coluna_q        <= '0;
      pendente_q      <= 1'b0;
      disparo_q       <= 1'b1;
      resp_acerto_q   <= 1'b0;
      resp_erro_q     <= 1'b0;
      resp_invalido_q <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      tiro_q          <= tiro_d;
      acerto_q        <= acerto_d;
      vidas_q         <= vidas_d;
      acertos_q       <= acertos_d;
      total_q         <= total_d;
      linha_q         <= linha_d;
      coluna_q        <= coluna_d;
      pendente_q      <= pendente_d;
      disparo_q       <= disparo_d;
      resp_acerto_q   <= resp_acerto_d;
      resp_erro_q     <= resp_erro_d;
      resp_invalido_q <= resp_invalido_d;
    end
  end

  assign {tiro4, tiro3, tiro2, tiro1, tiro0}           = tiro_q;
  assign {acerto4, acerto3, acerto2, acerto1, acerto0} = acerto_q;
  assign vidas         = vidas_q;
  assign acertos       = acertos_q;
  assign resp_acerto   = resp_acerto_q;
  assign resp_erro     = resp_erro_q;
  assign resp_invalido = resp_invalido_q;
  assign vitoria       = (estado_q == VITORIA);
  assign derrota       = (estado_q == DERROTA);

endmodule

// File: tb/tb_controlador_ataque.sv
// Bench for controlador_ataque: two instances (10 lives and 2 lives) share one
// stimulus stream; a game-level model predicts every output each cycle.
module tb_controlador_ataque;

  logic       clock = 1'b0;
  logic       reset, enable, disparo;
  logic [2:0] linha, coluna;
  logic [6:0] mapa [5];

  logic [4:0][6:0] t0, a0, t1, a1;
  logic [3:0]      v0, v1;
  logic [5:0]      h0, h1;
  logic            ra0, re0, ri0, vi0, de0;
  logic            ra1, re1, ri1, vi1, de1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  controlador_ataque #(.VIDAS_INICIAIS(10)) dut (
    .clock(clock), .reset(reset), .enable(enable), .linha(linha), .coluna(coluna),
    .disparo(disparo), .mapa0(mapa[0]), .mapa1(mapa[1]), .mapa2(mapa[2]),
    .mapa3(mapa[3]), .mapa4(mapa[4]),
    .tiro0(t0[0]), .tiro1(t0[1]), .tiro2(t0[2]), .tiro3(t0[3]), .tiro4(t0[4]),
    .acerto0(a0[0]), .acerto1(a0[1]), .acerto2(a0[2]), .acerto3(a0[3]), .acerto4(a0[4]),
    .vidas(v0), .acertos(h0), .resp_acerto(ra0), .resp_erro(re0),
    .resp_invalido(ri0), .vitoria(vi0), .derrota(de0)
  );

  controlador_ataque #(.VIDAS_INICIAIS(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .linha(linha), .coluna(coluna),
    .disparo(disparo), .mapa0(mapa[0]), .mapa1(mapa[1]), .mapa2(mapa[2]),
    .mapa3(mapa[3]), .mapa4(mapa[4]),
    .tiro0(t1[0]), .tiro1(t1[1]), .tiro2(t1[2]), .tiro3(t1[3]), .tiro4(t1[4]),
    .acerto0(a1[0]), .acerto1(a1[1]), .acerto2(a1[2]), .acerto3(a1[3]), .acerto4(a1[4]),
    .vidas(v1), .acertos(h1), .resp_acerto(ra1), .resp_erro(re1),
    .resp_invalido(ri1), .vitoria(vi1), .derrota(de1)
  );

  // ---------------- game model ----------------
  // status: 0 idle, 1 counting ships, 2 playing, 3 won, 4 lost.
  // A shot is aged in cycles from the edge that saw the fire rise; it is
  // scored when it reaches age 3 (two edges later).
  int         VID [2] = '{10, 2};
  logic [6:0] m_tiro [2][5];
  logic [6:0] m_acer [2][5];
  int         m_vidas [2], m_acertos [2], m_total [2], m_status [2];
  int         m_age [2], m_sr [2], m_sc [2];
  bit         m_prev [2], m_pa [2], m_pe [2], m_pi [2];

  task automatic limpa(input int k);
    for (int c = 0; c < 5; c++) begin
      m_tiro[k][c] = '0;
      m_acer[k][c] = '0;
    end
    m_vidas[k]   = VID[k];
    m_acertos[k] = 0;
    m_age[k]     = 0;
  endtask

  function automatic int conta_navios();
    int n = 0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++)
        if (mapa[c][r]) n++;
    return n;
  endfunction

  task automatic perde(input int k);
    m_tiro[k][m_sc[k]][m_sr[k]] = 1'b1;
    m_vidas[k]--;
    m_pe[k] = 1'b1;
    if (m_vidas[k] == 0) m_status[k] = 4;
  endtask

  task automatic pontua(input int k);
    if (m_sr[k] > 6 || m_sc[k] > 4) begin
      m_pi[k] = 1'b1;
    end else if (m_tiro[k][m_sc[k]][m_sr[k]]) begin
`ifdef TIRO_REPETIDO_PENALIDADE_EN
      perde(k);
`else
      m_pi[k] = 1'b1;
`endif
    end else if (mapa[m_sc[k]][m_sr[k]]) begin
      m_tiro[k][m_sc[k]][m_sr[k]] = 1'b1;
      m_acer[k][m_sc[k]][m_sr[k]] = 1'b1;
      m_acertos[k]++;
      m_pa[k] = 1'b1;
      if (m_acertos[k] == m_total[k]) m_status[k] = 3;
    end else begin
      perde(k);
    end
  endtask

  // Advance the model on every rising edge using the inputs sampled there.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      m_pa[k] = 1'b0; m_pe[k] = 1'b0; m_pi[k] = 1'b0;
      if (reset) begin
        limpa(k);
        m_status[k] = 0;
        m_prev[k]   = 1'b1;
      end else begin
        if (!enable) begin
          limpa(k);
          m_status[k] = 0;
        end else begin
          case (m_status[k])
            0: begin limpa(k); m_status[k] = 1; end
            1: begin
              m_total[k]  = conta_navios();
              m_status[k] = (m_total[k] == 0) ? 3 : 2;
            end
            2: begin
              if (m_age[k] > 0) begin
                m_age[k]++;
                if (m_age[k] == 3) begin
                  pontua(k);
                  m_age[k] = 0;
                end
              end else if (disparo && !m_prev[k]) begin
                m_age[k] = 1;
                m_sr[k]  = int'(linha);
                m_sc[k]  = int'(coluna);
              end
            end
            default: ;
          endcase
        end
        m_prev[k] = disparo;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [34:0] pk(input int k, input bit acer);
    logic [34:0] r;
    for (int c = 0; c < 5; c++) r[c*7 +: 7] = acer ? m_acer[k][c] : m_tiro[k][c];
    return r;
  endfunction

  // Compare both instances against the model on every falling edge.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("tiro",     t0, pk(0, 1'b0));
      chk("acerto",   a0, pk(0, 1'b1));
      chk("vidas",    v0, m_vidas[0]);
      chk("acertos",  h0, m_acertos[0]);
      chk("pulsos",   {ra0, re0, ri0}, {m_pa[0], m_pe[0], m_pi[0]});
      chk("flags",    {vi0, de0}, {m_status[0] == 3, m_status[0] == 4});
      chk("tiro_v2",    t1, pk(1, 1'b0));
      chk("acerto_v2",  a1, pk(1, 1'b1));
      chk("vidas_v2",   v1, m_vidas[1]);
      chk("acertos_v2", h1, m_acertos[1]);
      chk("pulsos_v2",  {ra1, re1, ri1}, {m_pa[1], m_pe[1], m_pi[1]});
      chk("flags_v2",   {vi1, de1}, {m_status[1] == 3, m_status[1] == 4});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic start_game(input logic [6:0] m0);
    reset = 1'b1; disparo = 1'b0;
    tick();
    reset = 1'b0;
    mapa[0] = m0;
    for (int c = 1; c < 5; c++) mapa[c] = '0;
    enable = 1'b1;
    tick();
    tick();
  endtask

  // Returns two edges after the edge that first sees disparo high.
  task automatic fire(input logic [2:0] r, input logic [2:0] c);
    linha = r; coluna = c; disparo = 1'b1;
    tick();
    disparo = 1'b0;
    tick();
    tick();
  endtask

  int n;
  int mode;

  initial begin
    reset = 1'b1; enable = 1'b0; disparo = 1'b0; linha = '0; coluna = '0;
    for (int c = 0; c < 5; c++) mapa[c] = '0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("lit_rst_vidas", v0, 4'd10);
    chk("lit_rst_vidas_v2", v1, 4'd2);
    chk("lit_rst_tiro", t0, 35'd0);
    chk("lit_rst_out", {vi0, de0, ra0, re0, ri0, h0}, 0);
    reset = 1'b0;

    // empty map: victory two edges after enable
    enable = 1'b1;
    tick();
    chk("lit_vit_vazio_cedo", vi0, 1'b0);
    tick();
    chk("lit_vit_vazio", vi0, 1'b1);

    // single ship hit at (0,0)
    start_game(7'h01);
    linha = 3'd0; coluna = 3'd0; disparo = 1'b1;
    tick();
    disparo = 1'b0;
    tick();
    chk("lit_latencia_e1", ra0, 1'b0);
    tick();
    chk("lit_acerto_pulso", ra0, 1'b1);
    chk("lit_acertos_1", h0, 6'd1);
    chk("lit_vitoria", vi0, 1'b1);
    chk("lit_tiro0", t0[0], 7'h01);
    chk("lit_acerto0", a0[0], 7'h01);
    tick();
    chk("lit_pulso_unico", ra0, 1'b0);

    // two misses on the 2-life instance
    start_game(7'h03);
    fire(3'd6, 3'd4);
    chk("lit_erro1_v2", {re1, v1}, {1'b1, 4'd1});
    fire(3'd5, 3'd4);
    chk("lit_erro2_v2", {re1, v1, de1}, {1'b1, 4'd0, 1'b1});
    fire(3'd0, 3'd0);
    chk("lit_derrota_surdo_v2", {ra1, re1, ri1, t1[0], de1}, {3'b000, 7'h00, 1'b1});

    // invalid coordinates, then repeated cell
    start_game(7'h03);
    fire(3'd7, 3'd2);
    chk("lit_invalido_linha", {ri0, v0}, {1'b1, 4'd10});
    fire(3'd2, 3'd5);
    chk("lit_invalido_coluna", {ri0, v0}, {1'b1, 4'd10});
    fire(3'd0, 3'd0);
    chk("lit_primeiro_acerto", {ra0, h0}, {1'b1, 6'd1});
    fire(3'd0, 3'd0);
`ifdef TIRO_REPETIDO_PENALIDADE_EN
    chk("lit_repetido", {re0, ri0, v0, h0}, {1'b1, 1'b0, 4'd9, 6'd1});
`else
    chk("lit_repetido", {re0, ri0, v0, h0}, {1'b0, 1'b1, 4'd10, 6'd1});
`endif

    // held fire gives one result; enable drop during evaluation discards it
    start_game(7'h03);
    linha = 3'd1; coluna = 3'd0; disparo = 1'b1;
    n = 0;
    repeat (10) begin
      tick();
      n += int'(ra0) + int'(re0) + int'(ri0);
    end
    chk("lit_segurado_um", n, 1);
    disparo = 1'b0;
    tick();
    linha = 3'd6; coluna = 3'd4; disparo = 1'b1;
    tick();
    disparo = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    chk("lit_enable_cai", {ra0, re0, ri0, t0, v0, h0}, {3'b000, 35'd0, 4'd10, 6'd0});

    // randomized games
    for (int ep = 0; ep < 60; ep++) begin
      if ($urandom_range(0, 3) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      mode = $urandom_range(0, 3);
      for (int c = 0; c < 5; c++) begin
        if (mode == 0)      mapa[c] = '0;
        else if (mode == 1) mapa[c] = 7'($urandom & $urandom & $urandom);
        else                mapa[c] = 7'($urandom & $urandom);
      end
      if (mode == 0) mapa[$urandom_range(0, 4)][$urandom_range(0, 6)] = 1'b1;
      enable = 1'b1;
      for (int t = 0; t < 50; t++) begin
        linha  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 6));
        coluna = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 4));
        if ($urandom_range(0, 2) == 0) disparo = ~disparo;
        enable = ($urandom_range(0, 79) != 0);
        if ($urandom_range(0, 59) == 0) mapa[$urandom_range(0, 4)] = 7'($urandom);
        tick();
      end
      enable = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
